// File: rtl/shift_issue_unit.sv
// Issue/capture stage for the left/right shift units: encodes a shift request into
// the units' operand/control bytes, captures the muxed result and hands it to write-back.
module shift_issue_unit #(
  parameter int DEST_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [7:0]        IN_OPERAND,
  input  logic [7:0]        IN_AMOUNT,
  input  logic [1:0]        IN_OP,
  input  logic [DEST_W-1:0] IN_DEST,
  output logic [7:0]        SH_DATA,
  output logic [7:0]        SH_CTRL,
  output logic              SH_DIR,
  input  logic [7:0]        SH_RESULT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [7:0]        RESULT,
  output logic [DEST_W-1:0] OUT_DEST
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic [3:0]        amt;
  logic [1:0]        mode;
  logic [7:0]        enc_ctrl;
  logic [DEST_W-1:0] dest_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (IN_VALID) state_next = EXEC;
      EXEC:    state_next = HOLD;
      HOLD:    if (OUT_READY) state_next = IN_VALID ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    IN_READY = RESET && ((state == IDLE) || ((state == HOLD) && OUT_READY));
    accept   = IN_VALID && IN_READY;
    // ror wraps modulo 8; the other shifts saturate at 8 so the units flush the operand
    if (IN_OP == 2'b11)           amt = {1'b0, IN_AMOUNT[2:0]};
    else if (IN_AMOUNT >= 8'd8)   amt = 4'd8;
    else                          amt = {1'b0, IN_AMOUNT[2:0]};
    unique case (IN_OP)
      2'b10:   mode = 2'b01;
      2'b11:   mode = 2'b10;
      default: mode = 2'b00;
    endcase
    enc_ctrl = {mode, 2'b00, amt};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      SH_DATA   <= '0;
      SH_CTRL   <= '0;
      SH_DIR    <= 1'b0;
      dest_q    <= '0;
      RESULT    <= '0;
      OUT_DEST  <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      if (accept) begin
        SH_DATA <= IN_OPERAND;
        SH_CTRL <= enc_ctrl;
        SH_DIR  <= (IN_OP != 2'b00);
        dest_q  <= IN_DEST;
      end
      if (state == EXEC) begin
        RESULT    <= SH_RESULT;
        OUT_DEST  <= dest_q;
        OUT_VALID <= 1'b1;
      end else if (state == HOLD && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: doc/shift_issue_unit.md
# shift_issue_unit

Sequential issue/capture stage that sits directly upstream of the left and right shift functional units in the ALU. It accepts a decoded shift request (operand, amount, shift type, destination register tag) over a valid/ready handshake. It translates the request into the 8-bit operand and control byte those units expect, then captures the selected unit's result one clock later. The result is presented with its destination tag to the register-file write-back path over a second valid/ready handshake.

## Interface
- DEST_W, default 3: width of destination register tag (8-entry register file).
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset; one clock domain only.
- IN_VALID  input  1  request present.
- IN_READY  output  1  unit can accept a request this cycle.
- IN_OPERAND  input  8  value to shift.
- IN_AMOUNT  input  8  unsigned shift amount, 0–255.
- IN_OP  input  2  00 sll, 01 srl, 10 sra, 11 ror.
- IN_DEST  input  DEST_W  destination register tag.
- SH_DATA  output  8  operand driven to both shift units (their data1).
- SH_CTRL  output  8  control byte to both shift units (their data2).
- SH_DIR  output  1  0 selects left-unit result, 1 selects right-unit result (drives external result mux).
- SH_RESULT  input  8  muxed shift-unit output; settles 2 time units after SH_DATA/SH_CTRL change.
- OUT_VALID  output  1  RESULT/OUT_DEST valid.
- OUT_READY  input  1  write-back accepts result.
- RESULT  output  8  captured shift result.
- OUT_DEST  output  DEST_W  tag of RESULT.

## Operation
- States: IDLE, EXEC, HOLD.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&&IN_READY at a posedge: register the operand and tag, register the encoded control byte, go to EXEC.
- Control encoding (registered at acceptance):
  - Amount field amt[3:0]:
    - sll, srl, sra: amt = 8 if IN_AMOUNT≥8, else IN_AMOUNT[2:0].
    - ror: amt = {1'b0, IN_AMOUNT[2:0]}, i.e. amount mod 8.
  - SH_CTRL = {mode[1:0], 2'b00, amt}.
    - mode = 00 for sll and srl.
    - mode = 01 for sra.
    - mode = 10 for ror.
  - SH_DIR = 0 for sll, 1 otherwise.
  - Bits [5:4] of SH_CTRL are always 0. The left unit compares the whole byte against 8, so mode must be 00 for sll.
- EXEC:
  - SH_DATA/SH_CTRL/SH_DIR are held stable.
  - At the next posedge: RESULT←SH_RESULT, OUT_DEST←registered tag, OUT_VALID←1, go to HOLD.
- HOLD:
  - RESULT, OUT_DEST and OUT_VALID are held stable while OUT_READY=0.
  - On OUT_VALID&&OUT_READY at a posedge:
    - If IN_VALID is also high at that edge, accept the new request and go to EXEC. OUT_VALID falls unless a new result is produced later.
    - Otherwise go to IDLE with OUT_VALID←0.
- IN_READY = (state==IDLE) || (state==HOLD && OUT_READY). This is a combinational path from OUT_READY; no path exists from IN_VALID to IN_READY.
- Amount 0 is not bypassed; it goes through the shifter (identity) with the same latency.
- SH_DATA/SH_CTRL/SH_DIR keep their last values in IDLE and HOLD. They change only on acceptance.

## Timing
- Reset asserted (RESET=0):
  - Takes effect immediately, independent of CLK.
  - State←IDLE.
  - OUT_VALID, RESULT, OUT_DEST, SH_DATA, SH_CTRL, SH_DIR ← 0.
  - IN_READY is forced to 0 while RESET=0.
- Reset during EXEC or HOLD discards the in-flight request; no OUT_VALID follows after release.
- First acceptance is possible at the first posedge after RESET deasserts.
- Latency: acceptance at edge N → OUT_VALID=1 after edge N+1.
- Throughput: one request per 2 cycles with OUT_READY tied high.
- Clock period must be ≥ 8 time units, leaving margin over the 2-unit shifter delay.
- Outputs change only on CLK rising edge or RESET falling edge. No outputs glitch besides IN_READY following OUT_READY.

## Test plan
- sll: reset, then request OPERAND=0x81, AMOUNT=1, OP=00, DEST=5 with OUT_READY=1.
  - SH_CTRL=0x01, SH_DIR=0 one edge after acceptance.
  - Next edge: OUT_VALID=1, RESULT=0x02, OUT_DEST=5.
- srl/sra saturation:
  - srl 0x80 by 8 → SH_CTRL=0x08, SH_DIR=1, RESULT=0x00.
  - sra 0x90 by 3 → SH_CTRL=0x43, RESULT=0xF2.
  - sra 0x90 by 200 → SH_CTRL=0x48, RESULT=0xFF.
- ror wrap: 0xB4 by 11 → SH_CTRL=0x83, RESULT=0x96. 0xB4 by 8 → SH_CTRL=0x80, RESULT=0xB4.
- Backpressure: hold OUT_READY=0 for 4 cycles after OUT_VALID.
  - RESULT, OUT_DEST, OUT_VALID stay stable; IN_READY=0; a pending IN_VALID is not accepted.
  - Raise OUT_READY: IN_READY=1 in the same cycle; the new request is accepted on that edge; its result appears 1 edge later.
- Reset mid-operation: drop RESET in EXEC between edges.
  - OUT_VALID=0, RESULT=0, SH_CTRL=0 immediately.
  - After release, no result is produced until a new request is accepted.
